// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional build macro: INSTR_FETCH_ALIGN_CHECK_EN (misaligned-redirect fault).
package instr_fetch_stage_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_t;

    // Canonical no-op (addi x0, x0, 0) presented when IF/ID holds no instruction
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_stage_if_id_register.sv
// IF/ID pipeline register: instruction, PC and a registered PC+4,
// with flush (highest priority), load, and hold-or-bubble behaviour.
module if_id_register
    import instr_fetch_stage_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 load,
    input  logic                 hold,
    input  logic [31:0]          load_instr,
    input  logic [WORD_SIZE-1:0] load_pc,
    output logic                 valid,
    output logic [31:0]          instr,
    output logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] pc_plus4
);

    // Pipeline register update: flush, then load, then bubble unless held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid    <= 1'b0;
            instr    <= INSTR_NOP;
            pc       <= '0;
            pc_plus4 <= WORD_SIZE'(4);
        end else if (flush) begin
            valid <= 1'b0;
            instr <= INSTR_NOP;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= load_instr;
            pc       <= load_pc;
            pc_plus4 <= load_pc + WORD_SIZE'(4);
        end else if (!hold) begin
            valid <= 1'b0;
            instr <= INSTR_NOP;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, single-outstanding instruction-memory request FSM,
// one-entry skid buffer for stalled responses, redirect/flush handling,
// and the IF/ID register feeding decode.
// Optional build macro: INSTR_FETCH_ALIGN_CHECK_EN -- misaligned redirect
// targets raise a sticky FetchFault and block all further requests.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter int unsigned           WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0]  RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 IMemReqValid,
    input  logic                 IMemReqReady,
    output logic [WORD_SIZE-1:0] IMemAddr,
    input  logic                 IMemRspValid,
    input  logic [31:0]          IMemRspData,
    input  logic                 DecodeStall,
    input  logic                 Redirect,
    input  logic [WORD_SIZE-1:0] RedirectTarget,
    output logic                 IFIDValid,
    output logic [31:0]          IFIDInstr,
    output logic [WORD_SIZE-1:0] IFIDPC,
    output logic [WORD_SIZE-1:0] IFIDPCPlus4,
    output logic [6:0]           Opcode,
    output logic [2:0]           Funct3,
    output logic [6:0]           Funct7,
    output logic                 FetchFault
);

    fetch_state_t         state;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] req_pc;
    logic [31:0]          skid_instr;
    logic                 skid_valid;
    logic                 fault;
    logic                 handshake;
    logic                 ifid_accept;
    logic                 ifid_load;
    logic [31:0]          ifid_load_instr;
    logic [WORD_SIZE-1:0] redirect_pc;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned  = |RedirectTarget[1:0];
    assign redirect_pc = RedirectTarget;
`else
    assign redirect_pc = RedirectTarget & ~{{(WORD_SIZE-2){1'b0}}, 2'b11};
    assign fault       = 1'b0;
`endif

    assign FetchFault   = fault;
    assign IMemAddr     = pc;
    assign IMemReqValid = (state == S_REQ) && !Redirect && !fault && !reset;
    assign handshake    = IMemReqValid && IMemReqReady;
    assign ifid_accept  = !IFIDValid || !DecodeStall;

    // IF/ID load: fresh response in S_WAIT or drained skid buffer in S_HOLD
    always_comb begin
        ifid_load       = 1'b0;
        ifid_load_instr = IMemRspData;
        if (!Redirect && ifid_accept) begin
            if (state == S_WAIT && IMemRspValid) begin
                ifid_load = 1'b1;
            end else if (state == S_HOLD && skid_valid) begin
                ifid_load       = 1'b1;
                ifid_load_instr = skid_instr;
            end
        end
    end

    // Fetch FSM, PC, skid buffer and fault flag; Redirect overrides everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_VECTOR;
            req_pc     <= '0;
            skid_instr <= INSTR_NOP;
            skid_valid <= 1'b0;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            fault      <= 1'b0;
`endif
        end else if (Redirect) begin
            skid_valid <= 1'b0;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            if (misaligned) fault <= 1'b1;
            else            pc    <= redirect_pc;
`else
            pc <= redirect_pc;
`endif
            // A request still in flight must have its response swallowed
            if ((state == S_WAIT || state == S_DROP) && !IMemRspValid) state <= S_DROP;
            else                                                       state <= S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (handshake) begin
                        req_pc <= pc;
                        pc     <= pc + WORD_SIZE'(4);
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (IMemRspValid) begin
                        if (ifid_accept) begin
                            state <= S_REQ;
                        end else begin
                            skid_instr <= IMemRspData;
                            skid_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!DecodeStall) begin
                        skid_valid <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (IMemRspValid) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

    if_id_register #(
        .WORD_SIZE (WORD_SIZE)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .flush      (Redirect),
        .load       (ifid_load),
        .hold       (DecodeStall),
        .load_instr (ifid_load_instr),
        .load_pc    (req_pc),
        .valid      (IFIDValid),
        .instr      (IFIDInstr),
        .pc         (IFIDPC),
        .pc_plus4   (IFIDPCPlus4)
    );

    assign Opcode = IFIDInstr[6:0];
    assign Funct3 = IFIDInstr[14:12];
    assign Funct7 = IFIDInstr[31:25];

endmodule
